// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locking arbiter for the write (enq) port of a synchronous FIFO.
// Optional idle-owner forced release is enabled by defining FIFO_ARB_TIMEOUT_EN.
module fifo_wr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int F_WIDTH = 8,
  parameter int PTR_W   = $clog2(N_REQ),
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_last,
  input  logic [N_REQ*F_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [F_WIDTH-1:0]         fifo_din,
  output logic                       fifo_enq,
  input  logic                       fifo_full,
  output logic [N_REQ-1:0]           grant,
  output logic                       busy,
  output logic                       err_timeout
);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e           state_q;
  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] owner_q;

  logic             cand_found;
  logic [PTR_W-1:0] cand_idx;
  logic             serve_on;
  logic [PTR_W-1:0] serve_idx;
  logic             accept;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == N_REQ - 1) ? '0 : p + 1'b1;
  endfunction

  // Cyclic search from rr_ptr; iterating from the far end lets the nearest hit win.
  always_comb begin
    logic [PTR_W-1:0] sel;
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sel = PTR_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (req_valid[sel]) begin
        cand_found = 1'b1;
        cand_idx   = sel;
      end
    end
  end

  assign serve_on  = (state_q == LOCKED) || cand_found;
  assign serve_idx = (state_q == LOCKED) ? owner_q : cand_idx;
  assign accept    = rst && serve_on && !fifo_full && req_valid[serve_idx];

  // Outputs are forced low while reset is held, independent of the inputs.
  always_comb begin
    grant     = '0;
    req_ready = '0;
    fifo_enq  = 1'b0;
    fifo_din  = '0;
    busy      = 1'b0;
    if (rst) begin
      if (serve_on) begin
        grant[serve_idx]     = 1'b1;
        req_ready[serve_idx] = !fifo_full;
      end
      fifo_enq = accept;
      if (accept) fifo_din = req_data[int'(serve_idx)*F_WIDTH +: F_WIDTH];
      busy = (state_q == LOCKED);
    end
  end

`ifdef FIFO_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] idle_cnt_q;
  logic             err_q;
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
`ifdef FIFO_ARB_TIMEOUT_EN
      idle_cnt_q <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
`ifdef FIFO_ARB_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (req_last[cand_idx]) begin
              rr_ptr_q <= wrap_inc(cand_idx);
            end else begin
              state_q <= LOCKED;
              owner_q <= cand_idx;
`ifdef FIFO_ARB_TIMEOUT_EN
              idle_cnt_q <= '0;
`endif
            end
          end
        end
        LOCKED: begin
          if (accept && req_last[owner_q]) begin
            state_q  <= IDLE;
            rr_ptr_q <= wrap_inc(owner_q);
          end
`ifdef FIFO_ARB_TIMEOUT_EN
          // Release on the edge that completes TIMEOUT consecutive owner-idle cycles.
          if (req_valid[owner_q]) begin
            idle_cnt_q <= '0;
          end else if (idle_cnt_q == CNT_W'(TIMEOUT - 1)) begin
            idle_cnt_q <= '0;
            state_q    <= IDLE;
            rr_ptr_q   <= wrap_inc(owner_q);
            err_q      <= 1'b1;
          end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares the single write (enq) port of the synchronous FIFO among N_REQ producers. Uses round-robin selection with packet locking: once a requester's first beat is accepted, it owns the port until its last-flagged beat is accepted. Sits between producer blocks and the FIFO's din/enq/full interface. Applies FIFO backpressure directly to the granted producer.

Parameters:
N_REQ, 4, number of requesters; legal range is 2 to 16.
F_WIDTH, 8, data width; matches the FIFO's F_WIDTH.
PTR_W, $clog2(N_REQ), width of the round-robin and owner indices.
TIMEOUT, 16, idle-owner cycles before forced release; used only by the optional feature.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset; asynchronous, active-low.
req_valid  in  N_REQ  per-requester beat valid.
req_last  in  N_REQ  per-requester marker for the last beat of a packet.
req_data  in  N_REQ*F_WIDTH  per-requester data; requester i occupies bits [i*F_WIDTH +: F_WIDTH].
req_ready  out  N_REQ  per-requester accept; a beat transfers when valid and ready are both high.
fifo_din  out  F_WIDTH  to FIFO din.
fifo_enq  out  1  to FIFO enq.
fifo_full  in  1  from FIFO full.
grant  out  N_REQ  one-hot requester currently served; all zero if none.
busy  out  1  high while in LOCKED.
err_timeout  out  1  one-cycle pulse on forced release; tied to 0 without the optional feature.

Behaviour:
- State: a two-state FSM (IDLE, LOCKED), plus the round-robin pointer rr_ptr and the lock owner owner.
- Reset (rst low, asynchronous): state=IDLE, rr_ptr=0, owner=0, timeout counter=0.
  - While in reset, grant, req_ready, fifo_enq and busy are all 0.
  - fifo_din=0 whenever fifo_enq is 0.
- All outputs are combinational from registered state and current inputs. There is zero-cycle latency from requester to FIFO; the FIFO captures data on the same edge the beat is accepted.
- IDLE:
  - cand = first i with req_valid[i]=1, searching cyclically from rr_ptr (rr_ptr, rr_ptr+1, ... wrapping modulo N_REQ).
  - If cand exists: grant[cand]=1.
  - If also fifo_full=0: req_ready[cand]=1, fifo_enq=1, fifo_din=req_data[cand].
    - If req_last[cand]=1: stay in IDLE; rr_ptr <= (cand+1) mod N_REQ.
    - Otherwise: go to LOCKED; owner <= cand.
  - If fifo_full=1: no transfer and no state change. Grant may move next cycle if the valid set changes.
- LOCKED:
  - grant[owner]=1; req_ready[owner] = !fifo_full; fifo_enq = req_valid[owner] & !fifo_full; fifo_din = req_data[owner].
  - All other req_ready are 0, even if the FIFO has space.
  - When a beat is accepted with req_last[owner]=1: go to IDLE; rr_ptr <= (owner+1) mod N_REQ.
  - If the owner drops req_valid mid-packet, the lock is held; there are no enqueues and no rotation.
- Wrap-around: when cand or owner equals N_REQ-1, rr_ptr goes to 0.
- Simultaneous events:
  - All requesters valid with single-beat packets: strict rotation 0,1,2,3,0,...
  - A requester that is continuously valid is served at least once every N_REQ packets.
- fifo_full high during a lock: a stall, not a release.
- fifo_enq is never asserted while fifo_full=1.
- Reset mid-packet: the lock is lost immediately. Beats already in the FIFO remain; recovering the partial packet is the producer's responsibility.

Optional Feature:
Macro FIFO_ARB_TIMEOUT_EN.
- Defined:
  - In LOCKED, a counter increments each cycle that req_valid[owner]=0 and clears on any owner-valid cycle.
  - When it reaches TIMEOUT, the next edge forces IDLE, sets rr_ptr <= owner+1 and pulses err_timeout for one cycle.
  - The counter resets on entry to LOCKED and on reset.
- Undefined: no counter; the lock is held indefinitely; err_timeout is constant 0.

Test Plan:
- Reset sequence: rst=0 while req_valid=4'b1111 -> grant=0, req_ready=0, fifo_enq=0. Release rst -> the same cycle grants requester 0.
- Round-robin: req_valid=4'b1111 and req_last=4'b1111 held for 8 cycles, fifo_full=0 -> grant sequence 0,1,2,3,0,1,2,3 with fifo_enq=1 on every cycle.
- Packet lock: req0 sends a 3-beat packet (data A0,A1,A2, last on A2) while req1 is continuously valid -> the FIFO sees A0,A1,A2 contiguously; req1's first beat follows on the next cycle; busy is high for 2 cycles.
- Backpressure: fifo_full=1 for 3 cycles mid-packet of req2 -> fifo_enq=0 and req_ready=0 during the stall; the lock is kept; the packet resumes with no lost or duplicated beats when full=0.
- Wrap: only req3 and req0 valid, single beats, rr_ptr at 3 -> grants alternate 3,0,3,0.
- FIFO_ARB_TIMEOUT_EN with TIMEOUT=16: req1 sends a first non-last beat, then deasserts valid -> exactly 16 idle cycles later err_timeout pulses, busy falls, and req2 (valid) is granted the next cycle.
